uart_line_echo: RTL and testbench

Line-assembly and echo stage between `uart_rx` and `uart_tx` in the UART echo test path. It accepts received bytes on a valid/ready byte stream and stores them in a line buffer until carriage return (0x0D). It then streams `"echo> "` + stored line + CR LF on a valid/ready byte stream toward `uart_tx`, and returns to receiving.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_line_mem.sv | 23 ++
 rtl/uart_line_echo.sv | 178 +++++++++++++++++
 tb/tb_uart_line_echo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, the echo prompt and the line-echo state type.
// Prompt helpers are used only when UART_LINE_ECHO_PROMPT_EN is defined.
package uart_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam int PROMPT_LEN = 6;
   localparam logic [8*PROMPT_LEN-1:0] PROMPT_STR = "echo> ";

   typedef enum logic [2:0] {
      RECV,
      PROMPT,
      BODY,
      TERM_CR,
      TERM_LF
   } line_echo_state_t;

   // First character of the string literal sits in the most significant byte.
   function automatic logic [7:0] prompt_byte(input logic [2:0] i);
      return PROMPT_STR[8*(PROMPT_LEN-1-int'(i)) +: 8];
   endfunction

endpackage

// File: rtl/uart_line_mem.sv
// Line buffer: DEPTH x 8 register file, synchronous write, asynchronous read.
// No reset on contents; no flow control of its own.
module uart_line_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_echo.sv
// Buffers rx bytes until CR, then echoes [prompt] + line + CR LF; first tx byte valid the cycle after CR.
// rx held off (rx_data_ready=0) while echoing; tx byte/valid held while tx_data_ready is low. Prompt: UART_LINE_ECHO_PROMPT_EN.
module uart_line_echo
   import uart_pkg::*;
#(
   parameter  int RBUF_SIZE = 64,
   localparam int CW        = $clog2(RBUF_SIZE + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_data_valid,
   output logic          rx_data_ready,
   output logic [7:0]    tx_data,
   output logic          tx_data_valid,
   input  logic          tx_data_ready,
   output logic [CW-1:0] line_len,
   output logic          overflow,
   output logic          line_done
);

   localparam int            AW     = (RBUF_SIZE > 1) ? $clog2(RBUF_SIZE) : 1;
   localparam logic [CW-1:0] SIZE_C = CW'(RBUF_SIZE);

   line_echo_state_t state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt, idx, idx_nxt, line_len_nxt;
   logic             ovf_nxt, done_nxt, txv_nxt, rdy_nxt, we;
   logic [7:0]       txd_nxt, rdata;
   logic [AW-1:0]    raddr;
`ifdef UART_LINE_ECHO_PROMPT_EN
   logic [2:0]       p_idx, p_idx_nxt;
`endif

   wire rx_fire = rx_data_valid && rx_data_ready;
   wire tx_fire = tx_data_valid && tx_data_ready;

   // Address 0 outside BODY so the first body byte is ready on entry.
   assign raddr = (state == BODY) ? idx[AW-1:0] + AW'(1) : '0;

   uart_line_mem #(.DEPTH(RBUF_SIZE), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (cnt[AW-1:0]),
      .wdata (rx_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RECV;
         cnt           <= '0;
         idx           <= '0;
         line_len      <= '0;
         overflow      <= 1'b0;
         line_done     <= 1'b0;
         tx_data       <= 8'h00;
         tx_data_valid <= 1'b0;
         rx_data_ready <= 1'b1;
`ifdef UART_LINE_ECHO_PROMPT_EN
         p_idx         <= '0;
`endif
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         idx           <= idx_nxt;
         line_len      <= line_len_nxt;
         overflow      <= ovf_nxt;
         line_done     <= done_nxt;
         tx_data       <= txd_nxt;
         tx_data_valid <= txv_nxt;
         rx_data_ready <= rdy_nxt;
`ifdef UART_LINE_ECHO_PROMPT_EN
         p_idx         <= p_idx_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      idx_nxt      = idx;
      line_len_nxt = line_len;
      ovf_nxt      = overflow;
      done_nxt     = 1'b0;
      txd_nxt      = tx_data;
      txv_nxt      = tx_data_valid;
      rdy_nxt      = rx_data_ready;
      we           = 1'b0;
`ifdef UART_LINE_ECHO_PROMPT_EN
      p_idx_nxt    = p_idx;
`endif
      case (state)
         RECV: begin
            if (rx_fire) begin
               if (rx_data == ASCII_CR) begin
                  line_len_nxt = cnt;
                  idx_nxt      = '0;
                  txv_nxt      = 1'b1;
                  rdy_nxt      = 1'b0;
`ifdef UART_LINE_ECHO_PROMPT_EN
                  state_nxt    = PROMPT;
                  p_idx_nxt    = '0;
                  txd_nxt      = prompt_byte(3'd0);
`else
                  if (cnt == '0) begin
                     state_nxt = TERM_CR;
                     txd_nxt   = ASCII_CR;
                  end else begin
                     state_nxt = BODY;
                     txd_nxt   = rdata;
                  end
`endif
               end else if (rx_data != ASCII_LF) begin
                  if (cnt < SIZE_C) begin
                     we      = 1'b1;
                     cnt_nxt = cnt + CW'(1);
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end
            end
         end
`ifdef UART_LINE_ECHO_PROMPT_EN
         PROMPT: begin
            if (tx_fire) begin
               if (p_idx == 3'(PROMPT_LEN - 1)) begin
                  if (line_len == '0) begin
                     state_nxt = TERM_CR;
                     txd_nxt   = ASCII_CR;
                  end else begin
                     state_nxt = BODY;
                     txd_nxt   = rdata;
                  end
               end else begin
                  p_idx_nxt = p_idx + 3'd1;
                  txd_nxt   = prompt_byte(p_idx + 3'd1);
               end
            end
         end
`endif
         BODY: begin
            if (tx_fire) begin
               if (idx + CW'(1) >= line_len) begin
                  state_nxt = TERM_CR;
                  txd_nxt   = ASCII_CR;
               end else begin
                  idx_nxt = idx + CW'(1);
                  txd_nxt = rdata;
               end
            end
         end
         TERM_CR: begin
            if (tx_fire) begin
               state_nxt = TERM_LF;
               txd_nxt   = ASCII_LF;
            end
         end
         TERM_LF: begin
            if (tx_fire) begin
               state_nxt = RECV;
               txv_nxt   = 1'b0;
               txd_nxt   = 8'h00;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
               done_nxt  = 1'b1;
               rdy_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = RECV;
            txv_nxt   = 1'b0;
            rdy_nxt   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo; expectations follow UART_LINE_ECHO_PROMPT_EN when defined.
module tb_uart_line_echo;

`ifdef UART_LINE_ECHO_PROMPT_EN
   localparam int PL = 6;
`else
   localparam int PL = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_valid = 1'b0;
   logic       rx_data_ready;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready = 1'b1;
   logic [6:0] line_len;
   logic       overflow;
   logic       line_done;

   uart_line_echo #(.RBUF_SIZE(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_data_ready (rx_data_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .line_len      (line_len),
      .overflow      (overflow),
      .line_done     (line_done)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   bit         stall_chk = 0;
   bit         stall_on = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_d = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transfer monitor and stall-hold checker, sampled on the falling edge.
   always @(negedge clk) begin
      if (tx_data_valid && tx_data_ready) got_q.push_back(tx_data);
      if (line_done) done_cnt++;
      if (stall_chk && prev_stall) begin
         chk("hold_vld", tx_data_valid, 1);
         chk("hold_dat", tx_data, prev_d);
      end
      prev_stall = tx_data_valid && !tx_data_ready;
      prev_d     = tx_data;
   end

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      rx_data = b;
      rx_data_valid = 1'b1;
      while (!rx_data_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!rx_data_ready) chk("rx_rdy_timeout", rx_data_ready, 1);
      @(posedge clk);
      #1;
      rx_data_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic build_exp(input string body);
      string pr = "echo> ";
      exp_q.delete();
      for (int i = 0; i < PL; i++) exp_q.push_back(pr[i]);
      for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic wait_done(input int budget, output int cycles);
      bit seen = 0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         seen = line_done;
      end
      chk("line_done_seen", seen, 1);
   endtask

   task automatic compare_echo(input string tag);
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
   endtask

   initial begin
      int    cyc;
      int    n0;
      string s;

      repeat (3) @(negedge clk);
      chk("rst_rx_rdy", rx_data_ready, 1);
      chk("rst_tx_vld", tx_data_valid, 0);
      chk("rst_tx_dat", tx_data, 8'h00);
      chk("rst_line_len", line_len, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_line_done", line_done, 0);
      rst_n = 1'b1;

      // "hi\r": latency, no bubbles, content, one pulse.
      build_exp("hi");
      send_str("hi");
      send_byte(8'h0D);
      chk("first_vld", tx_data_valid, 1);
      chk("first_dat", tx_data, exp_q[0]);
      chk("rx_rdy_echo", rx_data_ready, 0);
      wait_done(400, cyc);
      chk("hi_cycles", cyc, PL + 2 + 3);
      chk("hi_line_len", line_len, 2);
      @(negedge clk);
      chk("post_lf_vld", tx_data_valid, 0);
      chk("post_lf_rdy", rx_data_ready, 1);
      chk("done_pulses", done_cnt, 1);
      compare_echo("hi");

      // Empty line.
      build_exp("");
      send_byte(8'h0D);
      wait_done(400, cyc);
      chk("empty_cycles", cyc, PL + 3);
      chk("empty_line_len", line_len, 0);
      compare_echo("empty");

      // LF is dropped from the line.
      build_exp("a");
      send_str("a\n\r");
      wait_done(400, cyc);
      chk("lf_line_len", line_len, 1);
      compare_echo("lf_skip");

      // Overflow: 70 bytes into a 64-byte buffer.
      s = "";
      for (int i = 0; i < 64; i++) s = {s, "A"};
      build_exp(s);
      for (int i = 0; i < 70; i++) begin
         send_byte(8'h41);
         if (i == 63) chk("ovf_at_64", overflow, 0);
         if (i == 64) chk("ovf_at_65", overflow, 1);
      end
      send_byte(8'h0D);
      chk("ovf_during_echo", overflow, 1);
      wait_done(600, cyc);
      chk("ovf_cleared", overflow, 0);
      chk("ovf_line_len", line_len, 64);
      compare_echo("ovf");

      // Random tx stalls; rx traffic during the echo must be held off.
      build_exp("abc");
      send_str("abc");
      send_byte(8'h0D);
      stall_chk = 1;
      stall_on  = 1;
      fork
         begin
            while (stall_on) begin
               @(posedge clk);
               #1;
               tx_data_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      rx_data = 8'h5A;
      rx_data_valid = 1'b1;
      begin
         bit seen = 0;
         cyc = 0;
         while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            seen = line_done;
            if (seen) rx_data_valid = 1'b0;
            else if (cyc % 4 == 0) chk("rx_rdy_busy", rx_data_ready, 0);
         end
         rx_data_valid = 1'b0;
         chk("stall_done_seen", seen, 1);
      end
      stall_on  = 0;
      stall_chk = 0;
      repeat (2) @(posedge clk);
      #1;
      tx_data_ready = 1'b1;
      chk("stall_line_len", line_len, 3);
      compare_echo("stall");

      // Reset in the middle of the body.
      send_str("abcdefgh");
      send_byte(8'h0D);
      cyc = 0;
      while (got_q.size() < PL + 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_body", 32'(got_q.size() >= PL + 2), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_tx_vld", tx_data_valid, 0);
      chk("arst_rx_rdy", rx_data_ready, 1);
      chk("arst_line_len", line_len, 0);
      n0 = got_q.size();
      repeat (3) @(negedge clk);
      chk("arst_no_tx", got_q.size(), n0);
      rst_n = 1'b1;
      got_q.delete();
      build_exp("x");
      send_str("x\r");
      wait_done(400, cyc);
      chk("after_rst_len", line_len, 1);
      compare_echo("after_rst");

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
